// File: rtl/conv_window_ctrl_if.sv
// Handshake bundle between the line-buffer stage, the window controller and
// the MAC array.
//   slave  : the window controller (accepts columns, presents windows)
//   master : the surrounding datapath (offers columns, consumes windows)
interface conv_window_ctrl_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CW    = $clog2(IMG_W + 1),
    parameter int RW    = $clog2(IMG_H + 1)
);
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  shift_en,
        input  out_valid,
        input  out_col,
        input  out_row
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output shift_en,
        output out_valid,
        output out_col,
        output out_row
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequencing controller for the 3x3 sliding-window shift
// register. One 3-pixel column is accepted per handshake; once three columns
// of the same row band are in the window, a window is offered to the MAC
// array with its left column / top row index. The MAC can stall, which
// backpressures the column stream so no presented window is overwritten.
//
// Optional build macro CONV_WINDOW_CTRL_PERF_EN adds the saturating
// stall_cycles / starve_cycles performance counters.
module conv_window_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CW    = $clog2(IMG_W + 1),
    parameter int RW    = $clog2(IMG_H + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    conv_window_ctrl_if.slave bus,
    output logic              busy,
    output logic              frame_done
`ifdef CONV_WINDOW_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       starve_cycles
`endif
);

    localparam int            OUT_H      = IMG_H - 2;
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(OUT_H - 1);
    // A window exists only once columns 0,1,2 of the band are loaded.
    localparam logic [CW-1:0] COL_FILLED = CW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_cnt_next;
    logic [RW-1:0] row_cnt;
    logic [RW-1:0] row_cnt_next;

    logic          out_valid_q;
    logic          out_valid_next;
    logic [CW-1:0] out_col_q;
    logic [CW-1:0] out_col_next;
    logic [RW-1:0] out_row_q;
    logic [RW-1:0] out_row_next;

    logic          in_ready;
    logic          accept;
    logic          consume;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter and window-presentation decode
    always_comb begin
        state_next     = state;
        col_cnt_next   = col_cnt;
        row_cnt_next   = row_cnt;
        out_valid_next = out_valid_q;
        out_col_next   = out_col_q;
        out_row_next   = out_row_q;

        // Columns flow only while running and the presented window is
        // either empty or being consumed this cycle.
        in_ready = (state == RUN) && !abort && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        consume  = out_valid_q && bus.out_ready;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = RUN;
                    col_cnt_next = '0;
                    row_cnt_next = '0;
                end
            end

            RUN: begin
                if (accept) begin
                    // The first two shifts of a band only prime the window.
                    if (col_cnt >= COL_FILLED) begin
                        out_valid_next = 1'b1;
                        out_col_next   = col_cnt - COL_FILLED;
                        out_row_next   = row_cnt;
                    end else if (consume) begin
                        out_valid_next = 1'b0;
                    end

                    if (col_cnt == COL_LAST) begin
                        col_cnt_next = '0;
                        row_cnt_next = row_cnt + RW'(1);
                        if (row_cnt == ROW_LAST) begin
                            state_next = DRAIN;
                        end
                    end else begin
                        col_cnt_next = col_cnt + CW'(1);
                    end
                end else if (consume) begin
                    out_valid_next = 1'b0;
                end
            end

            DRAIN: begin
                // Wait for the final window to leave before signalling done.
                if (!out_valid_q || bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over every other event and suppresses frame_done.
        if (abort) begin
            state_next     = IDLE;
            col_cnt_next   = '0;
            row_cnt_next   = '0;
            out_valid_next = 1'b0;
            out_col_next   = '0;
            out_row_next   = '0;
        end
    end

    // Position counters and presented-window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt     <= '0;
            row_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_row_q   <= '0;
        end else begin
            col_cnt     <= col_cnt_next;
            row_cnt     <= row_cnt_next;
            out_valid_q <= out_valid_next;
            out_col_q   <= out_col_next;
            out_row_q   <= out_row_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.shift_en  = accept;
    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_row   = out_row_q;
    assign busy          = (state != IDLE);
    assign frame_done    = (state == DONE);

`ifdef CONV_WINDOW_CTRL_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Saturating stall/starve counters; cleared by an honoured start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= 16'd0;
            starve_cycles <= 16'd0;
        end else if (state == IDLE) begin
            if (start && !abort) begin
                stall_cycles  <= 16'd0;
                starve_cycles <= 16'd0;
            end
        end else begin
            if ((state == RUN || state == DRAIN) && out_valid_q && !bus.out_ready) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (state == RUN && in_ready && !bus.in_valid) begin
                starve_cycles <= sat_inc(starve_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl (IMG_W=5, IMG_H=4).
// A frame-level reference model tracks how many columns have been accepted;
// column k of the stream sits at (k % IMG_W, k / IMG_W), and every column at
// position >= 2 in its band produces one window that waits in a queue until
// the MAC side consumes it.
module tb_conv_window_ctrl;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int TOTAL = IMG_W * OUT_H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic frame_done;
`ifdef CONV_WINDOW_CTRL_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] starve_cycles;
`endif

    conv_window_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef CONV_WINDOW_CTRL_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .starve_cycles (starve_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit active = 1'b0;
    bit done_exp = 1'b0;
    int k = 0;
    int n_cons = 0;
    int done_seen = 0;
    int q_col[$];
    int q_row[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        active   = 1'b0;
        done_exp = 1'b0;
        k        = 0;
        q_col.delete();
        q_row.delete();
    endtask

    // One clock cycle: apply inputs, check at negedge, advance model at posedge.
    task automatic step(input logic iv, input logic ordy, input logic st, input logic ab);
        bit exp_ir;
        bit acc;
        bit cons;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        start         = st;
        abort         = ab;
        @(negedge clk);
        exp_ir = active && (k < TOTAL) && !ab && (q_col.size() == 0 || ordy);
        chk("in_ready", bus.in_ready, exp_ir);
        chk("shift_en", bus.shift_en, iv && exp_ir);
        chk("out_valid", bus.out_valid, q_col.size() != 0);
        if (q_col.size() != 0) begin
            chk("out_col", bus.out_col, q_col[0]);
            chk("out_row", bus.out_row, q_row[0]);
        end
        chk("busy", busy, active);
        chk("frame_done", frame_done, done_exp);
        acc  = iv && exp_ir;
        cons = (q_col.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (ab) begin
            model_reset();
        end else if (done_exp) begin
            done_exp = 1'b0;
            active   = 1'b0;
            done_seen++;
        end else if (!active) begin
            if (st) begin
                active = 1'b1;
                k      = 0;
                n_cons = 0;
            end
        end else begin
            if (cons) begin
                void'(q_col.pop_front());
                void'(q_row.pop_front());
                n_cons++;
            end
            if (acc) begin
                if ((k % IMG_W) >= 2) begin
                    q_col.push_back((k % IMG_W) - 2);
                    q_row.push_back(k / IMG_W);
                end
                k++;
            end
            if (cons && k == TOTAL && q_col.size() == 0) done_exp = 1'b1;
        end
    endtask

    // mode 0: continuous; 1: in_valid toggles; 2: random; 3: random + stray starts
    task automatic run_frame(input int mode, input int budget);
        int d0;
        int n;
        logic iv;
        logic ordy;
        logic st;
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < budget) begin
            iv = 1'b1; ordy = 1'b1; st = 1'b0;
            if (mode == 1) iv = (n % 2 == 0);
            if (mode >= 2) begin
                iv   = ($urandom % 4) != 0;
                ordy = ($urandom % 3) != 0;
            end
            if (mode == 3) st = ($urandom % 5) == 0;
            step(iv, ordy, st, 1'b0);
            n++;
        end
        chk("frame_completed", done_seen - d0, 1);
        chk("window_count", n_cons, OUT_W * OUT_H);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_col", bus.out_col, 0);
        chk("rst_out_row", bus.out_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // continuous streaming frame
        step(1'b1, 1'b1, 1'b1, 1'b0);
        run_frame(0, 100);

        // 4-cycle MAC stall right after the first window
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (q_col.size() == 0 && n < 20) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("first_window_seen", q_col.size(), 1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(0, 100);
`ifdef CONV_WINDOW_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles, 4);
        chk("starve_cycles", starve_cycles, 0);
`endif

        // in_valid toggling every other cycle
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(1, 200);

        // abort mid row 1 (col_cnt=3), then a clean frame
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (k < IMG_W + 3 && n < 40) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("abort_position", k, IMG_W + 3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(2, 1000);

        // randomized frames with stray start pulses while busy
        for (int f = 0; f < 4; f++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            run_frame(3, 2000);
        end

        // asynchronous reset mid-frame with a window presented
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_shift_en", bus.shift_en, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_col", bus.out_col, 0);
        chk("arst_out_row", bus.out_row, 0);
        chk("arst_busy", busy, 0);
        chk("arst_frame_done", frame_done, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        run_frame(2, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
